event_logger: RTL

Parametrised multi-channel signal-event logger. It watches CHANNELS input buses of WIDTH bits each and detects per-channel events: rising edge of bit 0, falling edge of bit 0, or any value change. Each event is queued as a timestamped record in a DEPTH-entry FIFO, which a consumer drains through a valid/ready handshake. It sits beside the simulation/debug harness as the synthesizable replacement for ad-hoc monitor-style event display.

---
 rtl/event_logger.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/event_logger.sv
// Multi-channel signal-event logger: per-channel edge/change detection, timestamped
// records in a show-ahead FIFO. Define EVLOG_DROP_CNT_EN to add the drop_cnt output.
module event_logger #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16,
    localparam int CIDW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNTW    = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] sig_in,
    input  logic [2*CHANNELS-1:0]     mode,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [TS_WIDTH-1:0]       ev_ts,
    output logic [CIDW-1:0]           ev_chan,
    output logic [WIDTH-1:0]          ev_value,
    output logic                      overflow,
    input  logic                      clr_ovf,
    output logic [CNTW-1:0]           ev_count
`ifdef EVLOG_DROP_CNT_EN
    ,
    output logic [15:0]               drop_cnt
`endif
);

    localparam int PTRW = $clog2(DEPTH);

    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [CIDW-1:0]     chan;
        logic [WIDTH-1:0]    value;
    } rec_t;

    logic [TS_WIDTH-1:0]       ts_q, ts_d;
    logic [CHANNELS*WIDTH-1:0] prev_q, prev_d;
    logic                      primed_q, primed_d;
    logic [CHANNELS-1:0]       pend_vld_q, pend_vld_d;
    logic [TS_WIDTH-1:0]       pend_ts_q [CHANNELS];
    logic [TS_WIDTH-1:0]       pend_ts_d [CHANNELS];
    logic [WIDTH-1:0]          pend_val_q [CHANNELS];
    logic [WIDTH-1:0]          pend_val_d [CHANNELS];
    rec_t                      mem_q [DEPTH];
    rec_t                      mem_d [DEPTH];
    logic [PTRW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]           count_q, count_d;
    logic                      ovf_q, ovf_d;

    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] grant;
    logic [CHANNELS-1:0] drop;
    logic                found;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                push;
    logic                can_push;
    rec_t                push_rec;
    rec_t                head;

    assign fifo_full  = (count_q == CNTW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && ev_ready;
    assign can_push   = !fifo_full || pop;

    always_comb begin
        hit = '0;
        if (primed_q) begin
            for (int i = 0; i < CHANNELS; i++) begin
                case (mode[2*i +: 2])
                    2'b01:   hit[i] = !prev_q[i*WIDTH] && sig_in[i*WIDTH];
                    2'b10:   hit[i] = prev_q[i*WIDTH] && !sig_in[i*WIDTH];
                    2'b11:   hit[i] = (sig_in[i*WIDTH +: WIDTH] != prev_q[i*WIDTH +: WIDTH]);
                    default: hit[i] = 1'b0;
                endcase
            end
        end
    end

    // Fixed-priority grant: the lowest-numbered pending channel drains first.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        push_rec = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (can_push && pend_vld_q[i] && !found) begin
                found          = 1'b1;
                grant[i]       = 1'b1;
                push_rec.ts    = pend_ts_q[i];
                push_rec.chan  = CIDW'(i);
                push_rec.value = pend_val_q[i];
            end
        end
        push = found;
    end

    // A slot emptied by this edge's grant can take a new hit immediately.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_ts_d  = pend_ts_q;
        pend_val_d = pend_val_q;
        drop       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pend_vld_d[i] = pend_vld_q[i] && !grant[i];
            if (hit[i]) begin
                if (pend_vld_q[i] && !grant[i]) begin
                    drop[i] = 1'b1;
                end else begin
                    pend_vld_d[i] = 1'b1;
                    pend_ts_d[i]  = ts_q;
                    pend_val_d[i] = sig_in[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_rec;
            wr_ptr_d        = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        count_d  = count_q + CNTW'(push) - CNTW'(pop);
        ovf_d    = (ovf_q && !clr_ovf) || (|drop);
        ts_d     = ts_q + TS_WIDTH'(1);
        prev_d   = sig_in;
        primed_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q       <= '0;
            prev_q     <= '0;
            primed_q   <= 1'b0;
            pend_vld_q <= '0;
            pend_ts_q  <= '{default: '0};
            pend_val_q <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            primed_q   <= primed_d;
            pend_vld_q <= pend_vld_d;
            pend_ts_q  <= pend_ts_d;
            pend_val_q <= pend_val_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef EVLOG_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    // A same-edge clear restarts from zero before adding this edge's drops.
    always_comb begin
        drop_sum = clr_ovf ? 17'd0 : {1'b0, drop_cnt_q};
        for (int i = 0; i < CHANNELS; i++) begin
            drop_sum = drop_sum + 17'(drop[i]);
        end
        drop_cnt_d = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign head     = mem_q[rd_ptr_q];
    assign ev_valid = !fifo_empty;
    assign ev_ts    = ev_valid ? head.ts    : '0;
    assign ev_chan  = ev_valid ? head.chan  : '0;
    assign ev_value = ev_valid ? head.value : '0;
    assign overflow = ovf_q;
    assign ev_count = count_q;

endmodule
